// File: rtl/life_pkg.sv
// Shared definitions for the Game-of-Life step engine: FSM states, edit opcodes, default sizes.
// No logic lives here; all widths derived from these defaults can be overridden per instance.
// Neighbour count width covers 0..8 inclusive.
package life_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_SET = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [1:0] OP_TGL = 2'b11;

  localparam int DEF_GRID_W = 32;
  localparam int DEF_GRID_H = 24;
  localparam int NB_W       = 4;

endpackage

// File: rtl/life_row_calc.sv
// Next-generation row from three neighbouring rows, B3/S23 rule with column wrap.
// Purely combinational, zero latency; no flow control.
// Column wrap is resolved at elaboration time, so each cell is a fixed 8-input adder.
module life_row_calc
  import life_pkg::*;
#(
  parameter int GRID_W = DEF_GRID_W
) (
  input  logic [GRID_W-1:0] above,
  input  logic [GRID_W-1:0] mid,
  input  logic [GRID_W-1:0] below,
  output logic [GRID_W-1:0] next_row
);

  for (genvar c = 0; c < GRID_W; c++) begin : g_col
    localparam int CL = (c + GRID_W - 1) % GRID_W;
    localparam int CR = (c + 1) % GRID_W;

    logic [NB_W-1:0] nb;

    assign nb = NB_W'(above[CL]) + NB_W'(above[c]) + NB_W'(above[CR]) +
                NB_W'(mid[CL])                     + NB_W'(mid[CR])   +
                NB_W'(below[CL]) + NB_W'(below[c]) + NB_W'(below[CR]);

    // Birth on exactly 3; survival on 2 or 3.
    assign next_row[c] = (nb == NB_W'(3)) || (mid[c] && (nb == NB_W'(2)));
  end

endmodule

// File: rtl/life_step_engine.sv
// Game-of-Life grid with one-row-per-cycle step into a shadow grid and a single-cycle commit.
// Step latency GRID_H+1 cycles from accepted step_req to step_done; rd_data has 1-cycle latency.
// No backpressure: step_req/edits outside IDLE are dropped, clear_all aborts anything in flight.
module life_step_engine
  import life_pkg::*;
#(
  parameter int GRID_W = DEF_GRID_W,
  parameter int GRID_H = DEF_GRID_H,
  parameter int ROW_AW = 5,
  parameter int COL_AW = 5,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_req,
  input  logic              clear_all,
  input  logic              edit_en,
  input  logic [ROW_AW-1:0] edit_row,
  input  logic [COL_AW-1:0] edit_col,
  input  logic [1:0]        edit_op,
  input  logic [ROW_AW-1:0] rd_row,
  output logic [GRID_W-1:0] rd_data,
  output logic              step_busy,
  output logic              step_done,
  output logic [15:0]       gen_count,
  output logic [CNT_W-1:0]  alive_count
);

  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(GRID_H - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ROW_AW-1:0] row_q;
  logic [ROW_AW-1:0] row_up;
  logic [ROW_AW-1:0] row_dn;
  logic              row_last;
  logic [GRID_W-1:0] cur    [GRID_H];
  logic [GRID_W-1:0] shadow [GRID_H];
  logic [GRID_W-1:0] next_row;
  logic [CNT_W-1:0]  acc;
  logic [CNT_W-1:0]  row_pop;
  logic              start_step;
  logic              edit_hit;
  logic              edit_row_ok;
  logic              edit_col_ok;
  logic              rd_row_ok;
  logic [GRID_W-1:0] edit_mask;
  logic [GRID_W-1:0] edit_word;

  assign row_last  = (row_q == LAST_ROW);
  assign row_up    = (row_q == '0) ? LAST_ROW : row_q - 1'b1;
  assign row_dn    = row_last ? '0 : row_q + 1'b1;
  assign step_busy = (state != ST_IDLE);

  assign edit_row_ok = ({1'b0, edit_row} < (ROW_AW + 1)'(GRID_H));
  assign edit_col_ok = ({1'b0, edit_col} < (COL_AW + 1)'(GRID_W));
  assign rd_row_ok   = ({1'b0, rd_row}   < (ROW_AW + 1)'(GRID_H));

  life_row_calc #(.GRID_W(GRID_W)) u_row_calc (
    .above    (cur[row_up]),
    .mid      (cur[row_q]),
    .below    (cur[row_dn]),
    .next_row (next_row)
  );

  // Population of the row currently being produced.
  always_comb begin
    row_pop = '0;
    for (int c = 0; c < GRID_W; c++) begin
      row_pop = row_pop + CNT_W'(next_row[c]);
    end
  end

  // Edit decode: edits only land in IDLE and lose to clear_all.
  always_comb begin
    edit_hit  = edit_en && (state == ST_IDLE) && !clear_all &&
                edit_row_ok && edit_col_ok && (edit_op != OP_NOP);
    edit_mask = GRID_W'(1) << edit_col;
    edit_word = edit_row_ok ? cur[edit_row] : '0;
    case (edit_op)
      OP_SET:  edit_word = edit_word | edit_mask;
      OP_CLR:  edit_word = edit_word & ~edit_mask;
      OP_TGL:  edit_word = edit_word ^ edit_mask;
      default: edit_word = edit_word;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state; clear_all forces IDLE from anywhere.
  always_comb begin
    state_nxt  = state;
    start_step = 1'b0;
    if (clear_all) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (step_req) begin
            state_nxt  = ST_CALC;
            start_step = 1'b1;
          end
        end
        ST_CALC:   if (row_last) state_nxt = ST_COMMIT;
        ST_COMMIT: state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // Grid storage: edits and commit write cur, CALC writes shadow row by row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < GRID_H; r++) begin
        cur[r]    <= '0;
        shadow[r] <= '0;
      end
    end else if (clear_all) begin
      for (int r = 0; r < GRID_H; r++) begin
        cur[r]    <= '0;
        shadow[r] <= '0;
      end
    end else begin
      if (edit_hit) cur[edit_row] <= edit_word;
      if (state == ST_CALC) shadow[row_q] <= next_row;
      if (state == ST_COMMIT) begin
        for (int r = 0; r < GRID_H; r++) cur[r] <= shadow[r];
      end
    end
  end

  // Row counter, population accumulator and generation bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q       <= '0;
      acc         <= '0;
      gen_count   <= '0;
      alive_count <= '0;
      step_done   <= 1'b0;
    end else if (clear_all) begin
      row_q       <= '0;
      acc         <= '0;
      gen_count   <= '0;
      alive_count <= '0;
      step_done   <= 1'b0;
    end else begin
      step_done <= 1'b0;
      if (start_step) begin
        row_q <= '0;
        acc   <= '0;
      end
      if (state == ST_CALC) begin
        acc <= acc + row_pop;
        if (!row_last) row_q <= row_q + 1'b1;
      end
      if (state == ST_COMMIT) begin
        alive_count <= acc;
        gen_count   <= gen_count + 16'd1;
        step_done   <= 1'b1;
      end
    end
  end

  // Display read port, always from the committed grid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            rd_data <= '0;
    else if (rd_row_ok) rd_data <= cur[rd_row];
    else                rd_data <= '0;
  end

endmodule

// File: tb/tb_life_step_engine.sv
// Directed bench for life_step_engine: reset, blinker, torus block, ignored requests,
// abort by clear, same-cycle edit+step, toggles and out-of-range accesses.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_life_step_engine;

  logic        clk;
  logic        rst;
  logic        step_req;
  logic        clear_all;
  logic        edit_en;
  logic [4:0]  edit_row;
  logic [4:0]  edit_col;
  logic [1:0]  edit_op;
  logic [4:0]  rd_row;
  logic [31:0] rd_data;
  logic        step_busy;
  logic        step_done;
  logic [15:0] gen_count;
  logic [9:0]  alive_count;

  int total;
  int bad;

  life_step_engine dut (
    .clk         (clk),
    .rst         (rst),
    .step_req    (step_req),
    .clear_all   (clear_all),
    .edit_en     (edit_en),
    .edit_row    (edit_row),
    .edit_col    (edit_col),
    .edit_op     (edit_op),
    .rd_row      (rd_row),
    .rd_data     (rd_data),
    .step_busy   (step_busy),
    .step_done   (step_done),
    .gen_count   (gen_count),
    .alive_count (alive_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_edit(input int r, input int c, input logic [1:0] op);
    edit_en  = 1'b1;
    edit_row = 5'(r);
    edit_col = 5'(c);
    edit_op  = op;
    tick();
    edit_en  = 1'b0;
    edit_op  = 2'b00;
  endtask

  task automatic do_clear();
    clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
  endtask

  task automatic read_row(input int r, output logic [31:0] d);
    rd_row = 5'(r);
    tick();
    d = rd_data;
  endtask

  // Starts a step and returns the number of edges from the accepting edge to step_done (-1 on timeout).
  task automatic run_step(output int cyc);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!step_done && cyc < 100);
    if (!step_done) cyc = -1;
  endtask

  task automatic count_nonzero_rows(output int n);
    logic [31:0] d;
    n = 0;
    for (int r = 0; r < 24; r++) begin
      read_row(r, d);
      if (d != 32'h0) n++;
    end
  endtask

  task automatic set_blinker_h();
    do_edit(5, 4, 2'b01);
    do_edit(5, 5, 2'b01);
    do_edit(5, 6, 2'b01);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step_req  = i[0];
      edit_en   = ~i[0];
      edit_op   = 2'b01;
      edit_row  = 5'd0;
      edit_col  = 5'd0;
      clear_all = i[1];
      tick();
    end
    total++;
    if (rd_data !== 32'h0 || step_busy !== 1'b0 || step_done !== 1'b0 ||
        gen_count !== 16'h0 || alive_count !== 10'h0) begin
      bad++;
      $display("FAIL reset_outputs got rd=%h busy=%b done=%b gen=%0d alive=%0d exp all 0",
               rd_data, step_busy, step_done, gen_count, alive_count);
    end
    step_req = 1'b0; edit_en = 1'b0; edit_op = 2'b00; clear_all = 1'b0;
    rst = 1'b0;
    tick();
    for (int r = 0; r < 24; r++) begin
      read_row(r, d);
      total++;
      if (d !== 32'h0) begin
        bad++;
        $display("FAIL reset_row%0d got=%h exp=00000000", r, d);
      end
    end
    total++;
    if (step_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle got busy=%b exp=0", step_busy);
    end
  endtask

  task automatic test_blinker();
    int          cyc;
    logic [31:0] d;
    set_blinker_h();
    run_step(cyc);
    total++;
    if (cyc != 25) begin
      bad++;
      $display("FAIL blinker_latency got=%0d exp=25", cyc);
    end
    total++;
    if (step_busy !== 1'b0) begin
      bad++;
      $display("FAIL blinker_busy_at_done got=%b exp=0", step_busy);
    end
    tick();
    total++;
    if (step_done !== 1'b0) begin
      bad++;
      $display("FAIL blinker_done_pulse got=%b exp=0", step_done);
    end
    for (int r = 3; r <= 7; r++) begin
      read_row(r, d);
      total++;
      if (d !== ((r >= 4 && r <= 6) ? 32'h0000_0020 : 32'h0)) begin
        bad++;
        $display("FAIL blinker_v_row%0d got=%h exp=%h", r, d,
                 (r >= 4 && r <= 6) ? 32'h0000_0020 : 32'h0);
      end
    end
    total++;
    if (alive_count !== 10'd3 || gen_count !== 16'd1) begin
      bad++;
      $display("FAIL blinker_counts got alive=%0d gen=%0d exp alive=3 gen=1", alive_count, gen_count);
    end
    run_step(cyc);
    for (int r = 4; r <= 6; r++) begin
      read_row(r, d);
      total++;
      if (d !== ((r == 5) ? 32'h0000_0070 : 32'h0)) begin
        bad++;
        $display("FAIL blinker_h_row%0d got=%h exp=%h", r, d, (r == 5) ? 32'h0000_0070 : 32'h0);
      end
    end
    total++;
    if (alive_count !== 10'd3 || gen_count !== 16'd2) begin
      bad++;
      $display("FAIL blinker_counts2 got alive=%0d gen=%0d exp alive=3 gen=2", alive_count, gen_count);
    end
  endtask

  task automatic test_torus_block();
    int          cyc;
    int          n;
    logic [31:0] d;
    do_clear();
    do_edit(0, 0, 2'b01);
    do_edit(0, 31, 2'b01);
    do_edit(23, 0, 2'b01);
    do_edit(23, 31, 2'b01);
    run_step(cyc);
    total++;
    if (cyc != 25 || alive_count !== 10'd4 || gen_count !== 16'd1) begin
      bad++;
      $display("FAIL torus_counts got cyc=%0d alive=%0d gen=%0d exp cyc=25 alive=4 gen=1",
               cyc, alive_count, gen_count);
    end
    read_row(0, d);
    total++;
    if (d !== 32'h8000_0001) begin
      bad++;
      $display("FAIL torus_row0 got=%h exp=80000001", d);
    end
    read_row(23, d);
    total++;
    if (d !== 32'h8000_0001) begin
      bad++;
      $display("FAIL torus_row23 got=%h exp=80000001", d);
    end
    count_nonzero_rows(n);
    total++;
    if (n != 2) begin
      bad++;
      $display("FAIL torus_other_rows got nonzero rows=%0d exp=2", n);
    end
  endtask

  task automatic test_ignored_requests();
    int          dones;
    logic [31:0] d;
    do_clear();
    set_blinker_h();
    dones = 0;
    step_req = 1'b1;
    tick();
    for (int k = 1; k <= 40; k++) begin
      step_req = (k <= 20);
      if (k >= 5 && k <= 8) begin
        edit_en  = 1'b1;
        edit_row = 5'd10;
        edit_col = 5'd10;
        edit_op  = 2'b01;
      end else begin
        edit_en = 1'b0;
        edit_op = 2'b00;
      end
      tick();
      if (step_done) dones++;
    end
    step_req = 1'b0;
    edit_en  = 1'b0;
    total++;
    if (dones != 1 || gen_count !== 16'd1) begin
      bad++;
      $display("FAIL repulse_done got dones=%0d gen=%0d exp dones=1 gen=1", dones, gen_count);
    end
    read_row(10, d);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL midcalc_edit_row10 got=%h exp=00000000", d);
    end
    read_row(5, d);
    total++;
    if (d !== 32'h0000_0020) begin
      bad++;
      $display("FAIL repulse_row5 got=%h exp=00000020", d);
    end
  endtask

  task automatic test_clear_abort();
    int cyc;
    int dones;
    int n;
    do_clear();
    set_blinker_h();
    run_step(cyc);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
    total++;
    if (step_busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_busy got=%b exp=0", step_busy);
    end
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (step_done) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL abort_no_done got dones=%0d exp=0", dones);
    end
    total++;
    if (gen_count !== 16'd0 || alive_count !== 10'd0) begin
      bad++;
      $display("FAIL abort_counts got gen=%0d alive=%0d exp gen=0 alive=0", gen_count, alive_count);
    end
    count_nonzero_rows(n);
    total++;
    if (n != 0) begin
      bad++;
      $display("FAIL abort_rows got nonzero rows=%0d exp=0", n);
    end
  endtask

  task automatic test_back_to_back();
    int          cyc;
    logic [31:0] d;
    do_clear();
    do_edit(3, 3, 2'b01);
    do_edit(3, 4, 2'b01);
    edit_en  = 1'b1;
    edit_row = 5'd3;
    edit_col = 5'd5;
    edit_op  = 2'b01;
    run_step(cyc);
    edit_en = 1'b0;
    edit_op = 2'b00;
    total++;
    if (cyc != 25 || alive_count !== 10'd3 || gen_count !== 16'd1) begin
      bad++;
      $display("FAIL edit_step_counts got cyc=%0d alive=%0d gen=%0d exp cyc=25 alive=3 gen=1",
               cyc, alive_count, gen_count);
    end
    for (int r = 2; r <= 4; r++) begin
      read_row(r, d);
      total++;
      if (d !== 32'h0000_0010) begin
        bad++;
        $display("FAIL edit_step_row%0d got=%h exp=00000010", r, d);
      end
    end
    do_edit(7, 7, 2'b11);
    read_row(7, d);
    total++;
    if (d !== 32'h0000_0080) begin
      bad++;
      $display("FAIL toggle_once got=%h exp=00000080", d);
    end
    do_edit(7, 7, 2'b11);
    read_row(7, d);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL toggle_twice got=%h exp=00000000", d);
    end
    do_edit(3, 4, 2'b10);
    read_row(3, d);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL edit_clear got=%h exp=00000000", d);
    end
    do_edit(24, 4, 2'b01);
    read_row(0, d);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL oob_edit_row0 got=%h exp=00000000", d);
    end
    read_row(2, d);
    read_row(25, d);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL oob_read got=%h exp=00000000", d);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    step_req  = 1'b0;
    clear_all = 1'b0;
    edit_en   = 1'b0;
    edit_row  = 5'd0;
    edit_col  = 5'd0;
    edit_op   = 2'b00;
    rd_row    = 5'd0;
    test_reset();
    test_blinker();
    test_torus_block();
    test_ignored_requests();
    test_clear_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
